// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter and the load extension logic.
// Mode encodings follow RISC-V funct3 for loads/stores.
package dmem_pkg;

   localparam int NUM_PORTS = 2;
   localparam int BYTE_W    = 8;

   typedef enum logic [2:0] {
      LS_B  = 3'b000,
      LS_H  = 3'b001,
      LS_W  = 3'b010,
      LS_BU = 3'b100,
      LS_HU = 3'b101
   } ls_mode_e;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_e;

   function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addrLo);
      logic bad;
      bad = 1'b0;
      case (mode)
         LS_H, LS_HU: bad = addrLo[0];
         LS_W:        bad = |addrLo;
         default:     bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic is_illegal_mode(input logic [2:0] mode);
      return (mode == 3'b011) || (mode == 3'b110) || (mode == 3'b111);
   endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
// Illegal modes produce zero so callers never see stale lane data.
module load_extend
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  mode_i,
   output logic [31:0] result_o
);

   logic [BYTE_W-1:0]   byteVal;
   logic [2*BYTE_W-1:0] halfVal;

   always_comb begin
      byteVal  = word_i[{addr_lo_i, 3'b000} +: BYTE_W];
      halfVal  = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
      result_o = '0;
      case (mode_i)
         LS_B:    result_o = {{24{byteVal[BYTE_W-1]}}, byteVal};
         LS_H:    result_o = {{16{halfVal[2*BYTE_W-1]}}, halfVal};
         LS_W:    result_o = word_i;
         LS_BU:   result_o = {24'd0, byteVal};
         LS_HU:   result_o = {16'd0, halfVal};
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the LSU (port 0) and the
// debug loader (port 1); each access takes one ACCESS cycle and answers with a response pulse.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
)(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_PORTS-1:0]                 req_valid_i,
   output logic [NUM_PORTS-1:0]                 req_ready_o,
   input  logic [NUM_PORTS-1:0]                 req_we_i,
   input  logic [NUM_PORTS-1:0][2:0]            req_mode_i,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata_i,
   output logic [NUM_PORTS-1:0]                 rsp_valid_o,
   output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
   output logic                                 rsp_err_o,
   output logic                                 mem_we_o,
   output logic [2:0]                           mem_ls_mode_o,
   output logic [ADDR_WIDTH-1:0]                mem_a_o,
   output logic [DATA_WIDTH-1:0]                mem_wd_o,
   input  logic [DATA_WIDTH-1:0]                mem_rd_i
);

   arb_state_e                state_q, state_d;
   logic                      lastGrant_q, lastGrant_d;
   logic                      owner_q, owner_d;
   logic                      we_q, we_d;
   logic [2:0]                mode_q, mode_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      err_q, err_d;
   logic [NUM_PORTS-1:0]      rspValid_q, rspValid_d;
   logic [DATA_WIDTH-1:0]     rspRdata_q, rspRdata_d;
   logic                      rspErr_q, rspErr_d;
   logic                      winner;
   logic                      handshake;
   logic [DATA_WIDTH-1:0]     extData;

   load_extend u_load_extend (
      .word_i    (mem_rd_i),
      .addr_lo_i (addr_q[1:0]),
      .mode_i    (mode_q),
      .result_o  (extData)
   );

   // Memory side is a pure view of the latched request, so it holds its value while idle.
   assign mem_a_o       = addr_q;
   assign mem_ls_mode_o = mode_q;
   assign mem_wd_o      = wdata_q;
   assign mem_we_o      = (state_q == ACCESS) && we_q && !err_q;
   assign rsp_valid_o   = rspValid_q;
   assign rsp_rdata_o   = rspRdata_q;
   assign rsp_err_o     = rspErr_q;

   // The port that did not win last time gets priority whenever it is asking.
   always_comb begin
      if (lastGrant_q == 1'b0) begin
         winner = req_valid_i[1] ? 1'b1 : 1'b0;
      end else begin
         winner = req_valid_i[0] ? 1'b0 : 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      owner_d     = owner_q;
      we_d        = we_q;
      mode_d      = mode_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      rspValid_d  = '0;
      rspRdata_d  = rspRdata_q;
      rspErr_d    = rspErr_q;
      req_ready_o = '0;
      handshake   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_valid_i) begin
               req_ready_o[winner] = 1'b1;
            end
            handshake = |(req_valid_i & req_ready_o);
            if (handshake) begin
               owner_d     = winner;
               lastGrant_d = winner;
               we_d        = req_we_i[winner];
               mode_d      = req_mode_i[winner];
               addr_d      = req_addr_i[winner];
               wdata_d     = req_wdata_i[winner];
               err_d       = is_misaligned(req_mode_i[winner], req_addr_i[winner][1:0])
                             || is_illegal_mode(req_mode_i[winner]);
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            rspValid_d[owner_q] = 1'b1;
            rspRdata_d          = (we_q || err_q) ? '0 : extData;
            rspErr_d            = err_q;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset deliberately parks last grant on port 1 so port 0 wins the first contest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         mode_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rspValid_q  <= '0;
         rspRdata_q  <= '0;
         rspErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         mode_q      <= mode_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         rspValid_q  <= rspValid_d;
         rspRdata_q  <= rspRdata_d;
         rspErr_q    <= rspErr_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single accesses, load extension, alternating grants,
// error responses and reset during a store.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        reqValid;
   logic [1:0]        reqReady;
   logic [1:0]        reqWe;
   logic [1:0][2:0]   reqMode;
   logic [1:0][31:0]  reqAddr;
   logic [1:0][31:0]  reqWdata;
   logic [1:0]        rspValid;
   logic [31:0]       rspRdata;
   logic              rspErr;
   logic              memWe;
   logic [2:0]        memLsMode;
   logic [31:0]       memA;
   logic [31:0]       memWd;
   logic [31:0]       memRd;

   int passCount  = 0;
   int failCount  = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (reqValid),
      .req_ready_o   (reqReady),
      .req_we_i      (reqWe),
      .req_mode_i    (reqMode),
      .req_addr_i    (reqAddr),
      .req_wdata_i   (reqWdata),
      .rsp_valid_o   (rspValid),
      .rsp_rdata_o   (rspRdata),
      .rsp_err_o     (rspErr),
      .mem_we_o      (memWe),
      .mem_ls_mode_o (memLsMode),
      .mem_a_o       (memA),
      .mem_wd_o      (memWd),
      .mem_rd_i      (memRd)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int port, input logic we, input logic [2:0] mode,
                                input logic [31:0] addr, input logic [31:0] wdata);
      reqValid[port] = 1'b1;
      reqWe[port]    = we;
      reqMode[port]  = mode;
      reqAddr[port]  = addr;
      reqWdata[port] = wdata;
   endtask

   // One uncontested request, checked through grant, ACCESS and response cycles.
   task automatic singleAccess(input string tag, input int port, input logic we, input logic [2:0] mode,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdWord,
                               input logic [31:0] expRdata, input logic expErr, input logic expMemWe);
      @(negedge clk);
      applyStimulus(port, we, mode, addr, wdata);
      memRd = rdWord;
      #1;
      checkOutput({tag, ".ready"}, 32'(reqReady), 32'(1 << port));
      @(negedge clk);
      reqValid = 2'b00;
      reqWdata[port] = 32'hFFFF_FFFF;
      #1;
      checkOutput({tag, ".readyAccess"}, 32'(reqReady), 32'd0);
      checkOutput({tag, ".memWe"}, 32'(memWe), 32'(expMemWe));
      checkOutput({tag, ".memA"}, memA, addr);
      checkOutput({tag, ".memWd"}, memWd, wdata);
      checkOutput({tag, ".rspValidEarly"}, 32'(rspValid), 32'd0);
      @(negedge clk);
      checkOutput({tag, ".rspValid"}, 32'(rspValid), 32'(1 << port));
      checkOutput({tag, ".rspRdata"}, rspRdata, expRdata);
      checkOutput({tag, ".rspErr"}, 32'(rspErr), 32'(expErr));
      checkOutput({tag, ".memWeAfter"}, 32'(memWe), 32'd0);
   endtask

   initial begin
      int expPort;
      int prevPort;
      rst_n    = 1'b0;
      reqValid = 2'b00;
      reqWe    = 2'b00;
      reqMode  = '0;
      reqAddr  = '0;
      reqWdata = '0;
      memRd    = 32'd0;

      repeat (2) @(negedge clk);
      checkOutput("reset.rspValid", 32'(rspValid), 32'd0);
      checkOutput("reset.memA", memA, 32'd0);
      checkOutput("reset.memWe", 32'(memWe), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset.ready", 32'(reqReady), 32'd0);

      singleAccess("lw0",  0, 1'b0, LS_W,  32'h0001_0000, 32'd0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
      singleAccess("sw1",  1, 1'b1, LS_W,  32'h0001_0004, 32'h1234_5678, 32'h0,         32'h0,         1'b0, 1'b1);
      singleAccess("lb",   0, 1'b0, LS_B,  32'h0001_0003, 32'd0,         32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 1'b0);
      singleAccess("lbu",  0, 1'b0, LS_BU, 32'h0001_0003, 32'd0,         32'h80FF_0000, 32'h0000_0080, 1'b0, 1'b0);
      singleAccess("lhu",  1, 1'b0, LS_HU, 32'h0001_0002, 32'd0,         32'h80FF_0000, 32'h0000_80FF, 1'b0, 1'b0);

      // Both ports hold valid; port 1 was granted last so port 0 goes first.
      @(negedge clk);
      applyStimulus(0, 1'b0, LS_W, 32'h0000_0100, 32'd0);
      applyStimulus(1, 1'b1, LS_W, 32'h0000_0200, 32'h55AA_55AA);
      memRd = 32'hA5A5_A5A5;
      #1;
      prevPort = 0;
      for (int g = 0; g < 6; g++) begin
         expPort = g % 2;
         checkOutput($sformatf("rr%0d.ready", g), 32'(reqReady), 32'(1 << expPort));
         if (g > 0) begin
            checkOutput($sformatf("rr%0d.rspValid", g), 32'(rspValid), 32'(1 << prevPort));
            checkOutput($sformatf("rr%0d.rspRdata", g), rspRdata, (prevPort == 0) ? 32'hA5A5_A5A5 : 32'd0);
         end
         @(negedge clk);
         checkOutput($sformatf("rr%0d.readyAccess", g), 32'(reqReady), 32'd0);
         checkOutput($sformatf("rr%0d.memWe", g), 32'(memWe), 32'(expPort));
         checkOutput($sformatf("rr%0d.memA", g), memA, (expPort == 1) ? 32'h0000_0200 : 32'h0000_0100);
         @(negedge clk);
         prevPort = expPort;
      end
      reqValid = 2'b00;
      #1;
      checkOutput("rr.lastRspValid", 32'(rspValid), 32'd2);
      checkOutput("rr.lastRspRdata", rspRdata, 32'd0);

      singleAccess("shMis",  0, 1'b1, LS_H,   32'h0001_0001, 32'h0000_BEEF, 32'h0, 32'h0, 1'b1, 1'b0);
      singleAccess("mode011", 1, 1'b0, 3'b011, 32'h0001_0000, 32'd0,        32'h1111_2222, 32'h0, 1'b1, 1'b0);
      singleAccess("lh",     0, 1'b0, LS_H,   32'h0001_0002, 32'd0,         32'h80FF_0000, 32'hFFFF_80FF, 1'b0, 1'b0);

      // Port 0 was granted last, so without reset port 1 would win the next contest.
      @(negedge clk);
      applyStimulus(0, 1'b1, LS_W, 32'h0001_0008, 32'hCAFE_F00D);
      #1;
      checkOutput("rst.ready", 32'(reqReady), 32'd1);
      @(negedge clk);
      reqValid = 2'b00;
      #1;
      checkOutput("rst.memWeBefore", 32'(memWe), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst.memWeDropped", 32'(memWe), 32'd0);
      checkOutput("rst.memA", memA, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("rst.noRsp", 32'(rspValid), 32'd0);
      @(negedge clk);
      checkOutput("rst.noRspLater", 32'(rspValid), 32'd0);
      applyStimulus(0, 1'b0, LS_W, 32'h0000_0300, 32'd0);
      applyStimulus(1, 1'b0, LS_W, 32'h0000_0400, 32'd0);
      #1;
      checkOutput("rst.firstGrant", 32'(reqReady), 32'd1);
      @(negedge clk);
      reqValid = 2'b00;
      checkOutput("rst.memA2", memA, 32'h0000_0300);
      @(negedge clk);
      checkOutput("rst.rspValid2", 32'(rspValid), 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
